// File: rtl/banco_registro_lector.sv
// Read-side sequencer for a two-read-port register bank: on start it walks the
// bank in pairs (low half on port A, high half on port B) and streams each word.
module banco_registro_lector #(
   parameter int AW = 3,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [AW-1:0] addrRa,
   output logic [AW-1:0] addrRb,
   input  logic [DW-1:0] datOutRa,
   input  logic [DW-1:0] datOutRb,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_addr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
);

   // With AW=1 there is a single pair; ptr keeps one bit that is never advanced.
   localparam int PW   = (AW > 1) ? AW - 1 : 1;
   localparam int HALF = 1 << (AW - 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(HALF - 1);

   typedef enum logic [2:0] {IDLE, CAPT, SEND_A, SEND_B, FIN} state_t;

   state_t        state;
   state_t        stateNext;
   logic [PW-1:0] ptr;
   logic [DW-1:0] bufA;
   logic [DW-1:0] bufB;
   logic          lastPair;

   assign lastPair = (ptr == LAST_PTR);

   generate
      if (AW == 1) begin : gSinglePair
         assign addrRa = '0;
         assign addrRb = '1;
      end else begin : gPairs
         assign addrRa = {1'b0, ptr};
         assign addrRb = {1'b1, ptr};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = CAPT;
         CAPT:    stateNext = SEND_A;
         SEND_A:  if (out_ready) stateNext = SEND_B;
         SEND_B:  if (out_ready) stateNext = lastPair ? FIN : CAPT;
         FIN:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Both halves are snapshotted together, so later bank writes cannot tear a pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr  <= '0;
         bufA <= '0;
         bufB <= '0;
      end else begin
         case (state)
            IDLE:    if (start) ptr <= '0;
            CAPT: begin
               bufA <= datOutRa;
               bufB <= datOutRb;
            end
            SEND_B:  if (out_ready && !lastPair) ptr <= ptr + PW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = 1'b1;
      done      = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_addr  = '0;
      case (state)
         IDLE:   busy = 1'b0;
         SEND_A: begin
            out_valid = 1'b1;
            out_data  = bufA;
            out_addr  = addrRa;
         end
         SEND_B: begin
            out_valid = 1'b1;
            out_data  = bufB;
            out_addr  = addrRb;
         end
         FIN:     done = 1'b1;
         default: ;
      endcase
   end

endmodule
